// File: rtl/fft_pkg.sv
// Shared types and helpers for the FP4 FFT frame controller.
package fft_pkg;

    localparam int unsigned SAMPLE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DRAIN
    } state_t;

    // Out-of-range sizes (0 or above the memory depth) fall back to the largest frame.
    function automatic int unsigned clamp_log2n(input int unsigned log2n,
                                                input int unsigned max_log2);
        if (log2n == 0 || log2n > max_log2)
            return max_log2;
        return log2n;
    endfunction

endpackage

// File: rtl/fft_skid_fifo2.sv
// Two-entry valid/ready buffer with occupancy output; absorbs read latency in DRAIN.
module fft_skid_fifo2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data,
    output logic [1:0]   occupancy
);

    logic [W-1:0] mem [2];
    logic         wptr;
    logic         rptr;
    logic [1:0]   cnt;
    logic         do_pop;
    logic         do_push;

    assign pop_valid = (cnt != 2'd0);
    assign pop_data  = mem[rptr];
    assign occupancy = cnt;
    assign do_pop    = pop_valid & pop_ready;
    assign do_push   = push_valid & ((cnt != 2'd2) | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= ~wptr;
            end
            if (do_pop)
                rptr <= ~rptr;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: load N samples, pulse start, await done, drain results.
// Optional RUN watchdog enabled by FFT_FRAME_CTRL_TIMEOUT_EN.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned MAX_N       = 32,
    parameter int unsigned ADDR_WIDTH  = $clog2(MAX_N),
    parameter int unsigned LOG2_W      = $clog2(ADDR_WIDTH + 1),
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LOG2_W-1:0]     cfg_log2n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic                  out_last,
    output logic                  ext_wr_en,
    output logic [ADDR_WIDTH-1:0] ext_wr_addr,
    output logic [7:0]            ext_wr_data,
    output logic [ADDR_WIDTH-1:0] ext_rd_addr,
    input  logic [7:0]            ext_rd_data,
    output logic                  fft_start,
    input  logic                  fft_done,
    output logic                  busy,
    output logic [7:0]            frame_cnt,
    output logic                  err_timeout
);

    localparam int unsigned MAX_LOG2 = $clog2(MAX_N);

    state_t                state;
    logic                  in_ready_r;
    logic                  fft_start_r;
    logic [7:0]            frame_cnt_r;
    logic [ADDR_WIDTH-1:0] wcnt;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [ADDR_WIDTH-1:0] new_last_idx;
    logic [ADDR_WIDTH-1:0] rcnt;
    logic [ADDR_WIDTH-1:0] ocnt;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  rd_done;
    logic                  rd_inflight;
    logic                  in_hs;
    logic                  pop;
    logic                  issue;
    logic                  fifo_valid;
    logic [SAMPLE_W-1:0]   fifo_data;
    logic [1:0]            occ;
    logic [2:0]            credit;

    assign in_hs       = in_valid & in_ready_r;
    assign in_ready    = in_ready_r;
    assign ext_wr_en   = in_hs;
    assign ext_wr_addr = in_hs ? wcnt : '0;
    assign ext_wr_data = in_hs ? in_data : '0;

    // Credit counts this cycle's pop so a full-rate drain keeps issuing every cycle.
    assign pop         = fifo_valid & out_ready;
    assign credit      = {1'b0, occ} - {2'b0, pop} + {2'b0, rd_inflight};
    assign issue       = (state == ST_DRAIN) && !rd_done && (credit < 3'd2);
    assign ext_rd_addr = issue ? rcnt : rd_addr_q;

    assign out_valid   = fifo_valid;
    assign out_data    = fifo_data;
    assign out_last    = fifo_valid && (ocnt == last_idx);
    assign busy        = (state != ST_IDLE);
    assign fft_start   = fft_start_r;
    assign frame_cnt   = frame_cnt_r;

    always_comb begin
        new_last_idx = ADDR_WIDTH'((32'd1 << clamp_log2n(32'(cfg_log2n), MAX_LOG2)) - 32'd1);
    end

`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [TCNT_W-1:0] tcnt;
    logic              err_r;
    assign err_timeout = err_r;
`else
    assign err_timeout = 1'b0;
`endif

    fft_skid_fifo2 #(.W(SAMPLE_W)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_valid (rd_inflight),
        .push_data  (ext_rd_data),
        .pop_valid  (fifo_valid),
        .pop_ready  (out_ready),
        .pop_data   (fifo_data),
        .occupancy  (occ)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            in_ready_r  <= 1'b0;
            fft_start_r <= 1'b0;
            frame_cnt_r <= '0;
            wcnt        <= '0;
            last_idx    <= '0;
            rcnt        <= '0;
            ocnt        <= '0;
            rd_addr_q   <= '0;
            rd_done     <= 1'b0;
            rd_inflight <= 1'b0;
`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
            tcnt        <= '0;
            err_r       <= 1'b0;
`endif
        end else begin
            fft_start_r <= 1'b0;
            rd_inflight <= issue;
            if (issue) begin
                rd_addr_q <= rcnt;
                rcnt      <= rcnt + 1'b1;
                if (rcnt == last_idx)
                    rd_done <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    in_ready_r <= 1'b1;
                    // Clamped N is always >= 2, so the first sample always leads to LOAD.
                    if (in_hs) begin
                        last_idx <= new_last_idx;
                        wcnt     <= ADDR_WIDTH'(1);
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_hs) begin
                        if (wcnt == last_idx) begin
                            wcnt        <= '0;
                            in_ready_r  <= 1'b0;
                            fft_start_r <= 1'b1;
                            state       <= ST_START;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                ST_START: begin
`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
                    tcnt <= '0;
`endif
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (fft_done) begin
                        rcnt    <= '0;
                        ocnt    <= '0;
                        rd_done <= 1'b0;
                        state   <= ST_DRAIN;
                    end
`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
                    else if (tcnt == TCNT_W'(TIMEOUT_CYC - 1)) begin
                        err_r      <= 1'b1;
                        in_ready_r <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                ST_DRAIN: begin
                    if (pop) begin
                        ocnt <= ocnt + 1'b1;
                        if (out_last) begin
                            frame_cnt_r <= frame_cnt_r + 1'b1;
                            in_ready_r  <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: vector table, random frames, reset and timeout sequences.
module tb_fft_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cfg_log2n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       ext_wr_en;
    logic [4:0] ext_wr_addr;
    logic [7:0] ext_wr_data;
    logic [4:0] ext_rd_addr;
    logic [7:0] ext_rd_data;
    logic       fft_start;
    logic       fft_done;
    logic       busy;
    logic [7:0] frame_cnt;
    logic       err_timeout;

    int checks   = 0;
    int failures = 0;

    fft_frame_ctrl #(.MAX_N(32), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst), .cfg_log2n(cfg_log2n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
        .ext_rd_addr(ext_rd_addr), .ext_rd_data(ext_rd_data),
        .fft_start(fft_start), .fft_done(fft_done),
        .busy(busy), .frame_cnt(frame_cnt), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // ---------------- FFT top model: memory, done pulse, 1-cycle read ----------------
    logic [7:0] mem [32];
    int         dcnt = 0;
    bit         done_en = 1'b1;

    always @(posedge clk) begin
        if (ext_wr_en) mem[ext_wr_addr] <= ext_wr_data;
        ext_rd_data <= mem[ext_rd_addr] + 8'h30;
        fft_done    <= 1'b0;
        if (fft_start && done_en) dcnt <= 20;
        else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) fft_done <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- monitor (samples at negedge) ----------------
    int         cyc = 0;
    bit         last_in_hs;
    bit         pop_last_seen;
    int         start_cnt, start_cyc, last_wr_cyc, done_cyc, first_pop_cyc, last_pop_cyc, err_cyc;
    logic [4:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    logic [7:0] out_q [$];
    bit         last_q [$];
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;

    always @(negedge clk) begin
        cyc++;
        last_in_hs = in_valid && in_ready;
        if (rst) begin
            if (ext_wr_en != last_in_hs) chk("wr_en_vs_handshake", ext_wr_en, last_in_hs);
            if (ext_wr_en) begin
                wr_addr_q.push_back(ext_wr_addr);
                wr_data_q.push_back(ext_wr_data);
                last_wr_cyc = cyc;
            end
            if (fft_start) begin start_cnt++; start_cyc = cyc; end
            if (fft_done) done_cyc = cyc;
            if (err_timeout && err_cyc < 0) err_cyc = cyc;
            if (prev_stall) begin
                chk("stall_valid_hold", out_valid, 1);
                chk("stall_data_hold", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                out_q.push_back(out_data);
                last_q.push_back(out_last);
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                if (out_last) pop_last_seen = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- out_ready driver ----------------
    int rmode = 0;
    int pc    = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: out_ready = 1'b1;
                1: begin out_ready = pat[pc % 4]; pc++; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); out_q.delete(); last_q.delete();
        start_cnt = 0; start_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
        first_pop_cyc = -1; last_pop_cyc = -1; err_cyc = -1;
        pop_last_seen = 1'b0; pc = 0;
    endtask

    task automatic push_sample(input logic [7:0] d, input int gap);
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk); #1;
            if (last_in_hs) begin in_valid = 1'b0; return; end
        end
        in_valid = 1'b0;
        chk("in_handshake_timeout", 0, 1);
    endtask

    task automatic load_frame(input int n, input bit gaps, input logic [7:0] d [32]);
        for (int i = 0; i < n; i++) begin
            push_sample(d[i], gaps ? int'($urandom_range(0, 2)) : 0);
            if (i == 0) cfg_log2n = 3'($urandom_range(0, 7));
        end
        @(negedge clk); #1;
        chk("in_ready_after_last", in_ready, 0);
        chk("start_after_last", fft_start, 1);
    endtask

    int exp_frames = 0;

    task automatic run_frame(input logic [2:0] l2, input int n, input bit gaps,
                             input int rm, input bit seq);
        logic [7:0] d [32];
        int         bad;
        bit         finished;
        clear_logs();
        rmode     = rm;
        cfg_log2n = l2;
        for (int i = 0; i < 32; i++) d[i] = seq ? 8'(8'h10 + i) : 8'($urandom);
        load_frame(n, gaps, d);
        finished = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk); #1;
            if (pop_last_seen) begin finished = 1'b1; break; end
        end
        chk("frame_complete", finished, 1);
        exp_frames = (exp_frames + 1) % 256;
        chk("busy_after_last", busy, 0);
        chk("frame_cnt", frame_cnt, exp_frames);
        chk("start_count", start_cnt, 1);
        chk("start_timing", start_cyc - last_wr_cyc, 1);
        chk("write_count", wr_addr_q.size(), n);
        bad = 0;
        for (int i = 0; i < wr_addr_q.size() && i < n; i++)
            if (wr_addr_q[i] !== 5'(i) || wr_data_q[i] !== d[i]) bad++;
        chk("write_log", bad, 0);
        chk("output_count", out_q.size(), n);
        bad = 0;
        for (int i = 0; i < out_q.size() && i < n; i++)
            if (out_q[i] !== 8'(d[i] + 8'h30) || last_q[i] !== (i == n - 1)) bad++;
        chk("output_log", bad, 0);
        if (rm == 0) begin
            chk("drain_latency", first_pop_cyc - done_cyc, 3);
            chk("drain_rate", last_pop_cyc - first_pop_cyc, n - 1);
        end
        rmode = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {in_ready, out_valid, out_data, out_last, ext_wr_en, ext_wr_addr,
                   ext_wr_data, ext_rd_addr, fft_start, busy, frame_cnt, err_timeout}, 0);
    endtask

    typedef struct {
        logic [2:0] l2;
        int         n;
        bit         gaps;
        int         rm;
        bit         seq;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{3'd3, 8,  1'b0, 0, 1'b1};
        vecs[1] = '{3'd3, 8,  1'b0, 1, 1'b1};
        vecs[2] = '{3'd7, 32, 1'b0, 0, 1'b0};
        vecs[3] = '{3'd0, 32, 1'b1, 2, 1'b0};
        vecs[4] = '{3'd1, 2,  1'b0, 1, 1'b0};
        vecs[5] = '{3'd2, 4,  1'b1, 0, 1'b0};
        vecs[6] = '{3'd4, 16, 1'b0, 2, 1'b0};
        vecs[7] = '{3'd6, 32, 1'b1, 1, 1'b0};
        vecs[8] = '{3'd5, 32, 1'b0, 0, 1'b0};

        rst = 1'b0; in_valid = 1'b0; in_data = '0; cfg_log2n = 3'd3;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        rst = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[k]) run_frame(vecs[k].l2, vecs[k].n, vecs[k].gaps, vecs[k].rm, vecs[k].seq);

        // Random frames against the size rule: 0 or >5 means 32, else 1<<log2n.
        for (int k = 0; k < 8; k++) begin
            logic [2:0] l2;
            int         n;
            l2 = 3'($urandom_range(0, 7));
            n  = (l2 == 0 || l2 > 5) ? 32 : (1 << l2);
            run_frame(l2, n, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
        end

        // Reset with three samples loaded: outputs clear at once, next frame restarts at 0.
        clear_logs();
        cfg_log2n = 3'd3;
        for (int i = 0; i < 3; i++) push_sample(8'(8'h20 + i), 0);
        in_valid = 1'b1;
        in_data  = 8'h99;
        rst      = 1'b0;
        #1;
        check_all_zero("reset_mid_load");
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_frames = 0;
        @(posedge clk); #1;
        run_frame(3'd3, 8, 1'b0, 0, 1'b1);

`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
        begin
            logic [7:0] d [32];
            bit         seen;
            clear_logs();
            done_en   = 1'b0;
            cfg_log2n = 3'd3;
            for (int i = 0; i < 32; i++) d[i] = 8'(i);
            load_frame(8, 1'b0, d);
            seen = 1'b0;
            for (int t = 0; t < 300; t++) begin
                @(posedge clk); #1;
                if (err_cyc >= 0) begin seen = 1'b1; break; end
            end
            chk("timeout_seen", seen, 1);
            chk("timeout_cycle", err_cyc - start_cyc, 65);
            chk("timeout_idle", busy, 0);
            chk("timeout_frame_cnt", frame_cnt, exp_frames);
            done_en = 1'b1;
        end
`else
        chk("err_timeout_tied", err_timeout, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Frame-level sequencer for the FP4 FFT top. Streams one frame of N complex FP4 samples into the ping-pong memory through the external write port, pulses start, and waits for done. It then drains the N results from the external read port to an output stream with valid/ready backpressure. Sits between the system streaming interfaces and the FFT top; it is the only driver of the FFT's external load/read ports and start.

Parameters:
MAX_N, 32, largest supported transform size (power of two)
ADDR_WIDTH, $clog2(MAX_N), memory address width
LOG2_W, $clog2(ADDR_WIDTH+1), width of cfg_log2n
TIMEOUT_CYC, 4096, watchdog limit in RUN (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
cfg_log2n  in  LOG2_W  log2 of frame size; sampled on first accepted input sample
in_valid  in  1  input sample valid
in_ready  out  1  controller accepts input sample
in_data  in  8  complex FP4 sample {re[7:4], im[3:0]}
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output sample
out_data  out  8  FFT result sample
out_last  out  1  marks sample N-1 of the frame
ext_wr_en  out  1  FFT top load write enable
ext_wr_addr  out  ADDR_WIDTH  natural-order load address (FFT top bit-reverses)
ext_wr_data  out  8  load data
ext_rd_addr  out  ADDR_WIDTH  result read address
ext_rd_data  in  8  result data, valid 1 cycle after ext_rd_addr
fft_start  out  1  single-cycle start pulse to FFT top
fft_done  in  1  FFT top completion pulse
busy  out  1  high in every state except IDLE
frame_cnt  out  8  completed-frame counter
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset values: all outputs 0. State IDLE; counters, skid buffer and frame_cnt cleared. A reset mid-frame abandons the frame with no further memory writes.
- States: IDLE, LOAD, START, RUN, DRAIN.
- IDLE: in_ready=1. On the first in_valid&in_ready:
  - latch N = 1<<cfg_log2n; cfg_log2n of 0 or >log2(MAX_N) is clamped to log2(MAX_N);
  - write the sample to address 0;
  - go to LOAD, or to START if N==1 (unreachable after clamping, since clamped N≥2).
- LOAD: in_ready=1. Each handshake drives ext_wr_en=1, ext_wr_addr=wcnt, ext_wr_data=in_data in the same cycle (combinational from the handshake) and increments wcnt. On the handshake with wcnt==N-1, go to START. in_valid low stalls with no timeout.
- START: in_ready=0. fft_start=1 for exactly one cycle, then RUN.
- RUN: in_ready=0. Wait for fft_done, then DRAIN with rcnt=0. fft_done outside RUN is ignored.
- DRAIN:
  - Issue ext_rd_addr=rcnt only when (skid_occupancy + reads_in_flight) < 2; increment rcnt per issue.
  - Read data returns one cycle later and is pushed into a 2-entry skid FIFO. out_valid = FIFO non-empty; out_data = FIFO head.
  - out_last=1 when the head is sample N-1.
  - On the out_valid&out_ready handshake with out_last: increment frame_cnt (wraps 255→0) and go to IDLE.
  - Sustained out_ready=1 gives 1 sample/cycle after a 2-cycle initial latency.
  - out_ready low holds out_data/out_valid stable and stops issue; no sample is dropped or duplicated.
- ext_rd_addr holds its last value when not issuing. ext_wr_en=0 outside IDLE/LOAD.

Optional Feature:
FFT_FRAME_CTRL_TIMEOUT_EN
- Defined: a counter runs in RUN. If it reaches TIMEOUT_CYC without fft_done, set err_timeout (sticky until reset) and go to IDLE, discarding the frame; frame_cnt is unchanged.
- Undefined: no counter, err_timeout tied 0, RUN waits indefinitely.

Decomposition:
- Shared package fft_pkg:
  - state enum encodings;
  - FP4 complex sample width (8);
  - clamp_log2n function.
- Natural sub-module: fft_skid_fifo2 (2-entry valid/ready buffer with occupancy output), instantiated in DRAIN.

Test Plan:
- cfg_log2n=3, 8 back-to-back samples 0x10..0x17 → ext_wr_addr 0..7 with matching data; fft_start pulses once, 1 cycle after the 8th write; in_ready=0 from that write's next cycle.
- Model fft_done 20 cycles after start; memory returns addr+0x40; out_ready=1 → out_data 0x40..0x47 on consecutive cycles, out_last only on 0x47; frame_cnt=1; busy drops the next cycle.
- Same drain with out_ready toggling 1,0,0,1 → 8 samples in order, no duplicates or drops, out_data stable while stalled.
- cfg_log2n=7 with MAX_N=32 → exactly 32 writes before fft_start.
- Assert rst low mid-LOAD at wcnt=3 → all outputs 0 immediately; the next frame starts at ext_wr_addr 0.
- With FFT_FRAME_CTRL_TIMEOUT_EN and TIMEOUT_CYC=64, never assert fft_done → err_timeout=1 at cycle 64 of RUN, state IDLE, frame_cnt unchanged.
